wb_regfile: RTL and testbench

Writeback stage and architectural register file of the 5-stage RV32I pipeline, sitting directly downstream of the MEM/WB pipeline register. It formats raw load data by funct3 and byte offset, and selects the writeback source (load, ALU or PC+4). It commits the result to a 32×32 register file and serves the two combinational read ports used by decode, with same-cycle write-through bypass. It also exports the writeback result for EX forwarding and keeps a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/wb_regfile_load_ext.sv | 41 ++++
 rtl/wb_regfile.sv | 90 +++++++++
 tb/tb_wb_regfile.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I pipeline: writeback select encoding,
// load funct3 codes and the canonical bubble instruction.
package cpu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // Writeback source select; 2'b11 is unused and behaves like WB_ALU.
    typedef enum logic [1:0] {
        WB_MEM = 2'b00,
        WB_ALU = 2'b01,
        WB_PC4 = 2'b10
    } wbsel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // addi x0, x0, 0 -- inserted by the pipeline as a bubble.
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // An instruction retires unless it is a bubble or an all-zero slot.
    function automatic logic retires(input logic [XLEN-1:0] instr);
        return (instr != NOP_INSTR) && (instr != '0);
    endfunction

endpackage

// File: rtl/wb_regfile_load_ext.sv
// Load formatter: extracts the addressed byte/halfword from the aligned
// memory word and sign- or zero-extends it according to funct3.
module load_ext
    import cpu_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and halfword lanes from the raw word.
    always_comb begin
        byte_sel = raw_i[7:0];
        case (off_i)
            2'd0:    byte_sel = raw_i[7:0];
            2'd1:    byte_sel = raw_i[15:8];
            2'd2:    byte_sel = raw_i[23:16];
            default: byte_sel = raw_i[31:24];
        endcase
        // Halfword position comes from off[1] only; off[0] is ignored.
        half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];
    end

    // Extend the selected lane; any unrecognised funct3 passes the word through.
    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {24'h0, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {16'h0, half_sel};
            F3_LW:   data_o = raw_i;
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus architectural register file: selects the writeback
// source, commits it to x1..x31, serves two bypassed read ports for decode
// and counts retired instructions.
module wb_regfile
    import cpu_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [31:0]     instr_WB,
    input  logic [31:0]     lddata_WB,
    input  logic [31:0]     aludata_WB,
    input  logic [31:0]     pcfour_WB,
    input  logic [1:0]      WBSel_WB,
    input  logic            RegWEn_WB,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    output logic [31:0]     rs1_data_o,
    output logic [31:0]     rs2_data_o,
    output logic [31:0]     wb_data_o,
    output logic [4:0]      wb_rd_o,
    output logic            wb_en_o,
    output logic [31:0]     instret_o
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] instret_q;
    logic [XLEN-1:0] instret_d;
    logic [XLEN-1:0] load_val;

    load_ext u_load_ext (
        .funct3_i (instr_WB[14:12]),
        .off_i    (aludata_WB[1:0]),
        .raw_i    (lddata_WB),
        .data_o   (load_val)
    );

    assign wb_rd_o   = instr_WB[11:7];
    // Writes to x0 and writes while reset is held are squashed here, which
    // also keeps them out of the bypass path.
    assign wb_en_o   = RegWEn_WB && (wb_rd_o != 5'd0) && rst_ni;
    assign instret_o = instret_q;

    // Writeback source mux; the unused 2'b11 code falls back to the ALU result.
    always_comb begin
        wb_data_o = aludata_WB;
        case (wbsel_e'(WBSel_WB))
            WB_MEM:  wb_data_o = load_val;
            WB_PC4:  wb_data_o = pcfour_WB;
            default: wb_data_o = aludata_WB;
        endcase
    end

    // Read ports: x0 reads zero, a same-cycle write to the address is forwarded.
    always_comb begin
        rs1_data_o = '0;
        rs2_data_o = '0;
        if (rst_ni) begin
            if (rs1_addr_i != 5'd0) begin
                if (wb_en_o && (rs1_addr_i == wb_rd_o)) rs1_data_o = wb_data_o;
                else                                    rs1_data_o = regs_q[rs1_addr_i];
            end
            if (rs2_addr_i != 5'd0) begin
                if (wb_en_o && (rs2_addr_i == wb_rd_o)) rs2_data_o = wb_data_o;
                else                                    rs2_data_o = regs_q[rs2_addr_i];
            end
        end
    end

    // Register array: cleared in one cycle on reset, otherwise one write per cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_en_o) begin
            regs_q[wb_rd_o] <= wb_data_o;
        end
    end

    // Next retired-instruction count; bubbles and empty slots do not retire.
    always_comb begin
        instret_d = instret_q;
        if (retires(instr_WB)) instret_d = instret_q + 32'd1;
    end

    // Retired-instruction counter, free-running with natural wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) instret_q <= '0;
        else         instret_q <= instret_d;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table of per-cycle vectors with
// expected combinational outputs, a queue scoreboard, and hand-written
// sequences for counter wrap and mid-stream reset.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [31:0] instr_WB, lddata_WB, aludata_WB, pcfour_WB;
    logic [1:0]  WBSel_WB;
    logic        RegWEn_WB;
    logic [4:0]  rs1_addr_i, rs2_addr_i;
    logic [31:0] rs1_data_o, rs2_data_o, wb_data_o, instret_o;
    logic [4:0]  wb_rd_o;
    logic        wb_en_o;

    wb_regfile dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .instr_WB   (instr_WB),
        .lddata_WB  (lddata_WB),
        .aludata_WB (aludata_WB),
        .pcfour_WB  (pcfour_WB),
        .WBSel_WB   (WBSel_WB),
        .RegWEn_WB  (RegWEn_WB),
        .rs1_addr_i (rs1_addr_i),
        .rs2_addr_i (rs2_addr_i),
        .rs1_data_o (rs1_data_o),
        .rs2_data_o (rs2_data_o),
        .wb_data_o  (wb_data_o),
        .wb_rd_o    (wb_rd_o),
        .wb_en_o    (wb_en_o),
        .instret_o  (instret_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] instr, ld, alu, pc;
        logic [1:0]  sel;
        logic        wen;
        logic [4:0]  a1, a2;
        logic [31:0] e1, e2, ewb;
        logic        een;
    } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] LD  = 32'h80FF_7F01;

    vec_t        tbl[$];
    vec_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          vidx  = 0;
    logic [31:0] exp_instret = '0;
    logic [31:0] base;

    function automatic logic [31:0] mki(input logic [4:0] rd, input logic [2:0] f3);
        return {17'h0, f3, rd, 7'b0000011};
    endfunction

    function automatic vec_t mkv(input logic rst, input logic [31:0] instr, ld, alu, pc,
                                 input logic [1:0] sel, input logic wen,
                                 input logic [4:0] a1, a2,
                                 input logic [31:0] e1, e2, ewb, input logic een);
        vec_t v;
        v.rst = rst; v.instr = instr; v.ld = ld; v.alu = alu; v.pc = pc;
        v.sel = sel; v.wen = wen; v.a1 = a1; v.a2 = a2;
        v.e1 = e1; v.e2 = e2; v.ewb = ewb; v.een = een;
        return v;
    endfunction

    function automatic logic counts(input logic [31:0] i);
        return (i != NOP) && (i != 32'h0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vec %0d): got %h, want %h", name, vidx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, compare outputs mid-cycle, then clock it in.
    task automatic apply(input vec_t v);
        vec_t e;
        rst_ni = v.rst; instr_WB = v.instr; lddata_WB = v.ld; aludata_WB = v.alu;
        pcfour_WB = v.pc; WBSel_WB = v.sel; RegWEn_WB = v.wen;
        rs1_addr_i = v.a1; rs2_addr_i = v.a2;
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check("rs1_data", rs1_data_o, e.e1);
        check("rs2_data", rs2_data_o, e.e2);
        check("wb_data",  wb_data_o,  e.ewb);
        check("wb_en",    {31'h0, wb_en_o}, {31'h0, e.een});
        check("wb_rd",    {27'h0, wb_rd_o}, {27'h0, e.instr[11:7]});
        check("instret",  instret_o,  exp_instret);
        @(posedge clk);
        if (!e.rst)              exp_instret = '0;
        else if (counts(e.instr)) exp_instret = exp_instret + 32'd1;
        #1;
        vidx++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a write pending: nothing visible, nothing enabled.
        apply(mkv(0, mki(3, 3'b000), 0, 32'h0000_00AA, 0, 2'b01, 1, 3, 3, 0, 0, 32'h0000_00AA, 0));
        apply(mkv(0, mki(3, 3'b000), 0, 32'h0000_00AA, 0, 2'b01, 1, 3, 0, 0, 0, 32'h0000_00AA, 0));

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++)
            apply(mkv(1, NOP, 0, 0, 0, 2'b01, 0, 5'(i), 5'(31 - i), 0, 0, 0, 0));

        // Main table: x0 writes, bypass, load formatting, source select.
        tbl.push_back(mkv(1, mki(0, 3'b000), 0, 32'hDEAD_BEEF, 0, 2'b01, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 0));
        tbl.push_back(mkv(1, NOP, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mkv(1, mki(5, 3'b000), 0, 32'h1234_5678, 0, 2'b01, 1, 5, 5, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1));
        tbl.push_back(mkv(1, NOP, 0, 0, 0, 2'b01, 0, 5, 0, 32'h1234_5678, 0, 0, 0));
        tbl.push_back(mkv(1, mki(1, 3'b000), LD, 3, 0, 2'b00, 1, 1, 5, 32'hFFFF_FF80, 32'h1234_5678, 32'hFFFF_FF80, 1));
        tbl.push_back(mkv(1, mki(1, 3'b100), LD, 3, 0, 2'b00, 1, 1, 1, 32'h0000_0080, 32'h0000_0080, 32'h0000_0080, 1));
        tbl.push_back(mkv(1, mki(1, 3'b000), LD, 0, 0, 2'b00, 1, 1, 5, 32'h0000_0001, 32'h1234_5678, 32'h0000_0001, 1));
        tbl.push_back(mkv(1, mki(1, 3'b000), LD, 1, 0, 2'b00, 1, 1, 5, 32'h0000_007F, 32'h1234_5678, 32'h0000_007F, 1));
        tbl.push_back(mkv(1, mki(1, 3'b000), LD, 2, 0, 2'b00, 1, 1, 5, 32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 1));
        tbl.push_back(mkv(1, mki(1, 3'b100), LD, 2, 0, 2'b00, 1, 1, 5, 32'h0000_00FF, 32'h1234_5678, 32'h0000_00FF, 1));
        tbl.push_back(mkv(1, mki(1, 3'b001), LD, 2, 0, 2'b00, 1, 1, 5, 32'hFFFF_80FF, 32'h1234_5678, 32'hFFFF_80FF, 1));
        tbl.push_back(mkv(1, mki(1, 3'b001), LD, 3, 0, 2'b00, 1, 1, 5, 32'hFFFF_80FF, 32'h1234_5678, 32'hFFFF_80FF, 1));
        tbl.push_back(mkv(1, mki(1, 3'b001), LD, 0, 0, 2'b00, 1, 1, 5, 32'h0000_7F01, 32'h1234_5678, 32'h0000_7F01, 1));
        tbl.push_back(mkv(1, mki(1, 3'b101), LD, 0, 0, 2'b00, 1, 1, 5, 32'h0000_7F01, 32'h1234_5678, 32'h0000_7F01, 1));
        tbl.push_back(mkv(1, mki(1, 3'b101), LD, 1, 0, 2'b00, 1, 1, 5, 32'h0000_7F01, 32'h1234_5678, 32'h0000_7F01, 1));
        tbl.push_back(mkv(1, mki(1, 3'b101), LD, 2, 0, 2'b00, 1, 1, 5, 32'h0000_80FF, 32'h1234_5678, 32'h0000_80FF, 1));
        tbl.push_back(mkv(1, mki(1, 3'b010), LD, 2, 0, 2'b00, 1, 1, 5, LD, 32'h1234_5678, LD, 1));
        tbl.push_back(mkv(1, mki(1, 3'b011), LD, 1, 0, 2'b00, 1, 1, 5, LD, 32'h1234_5678, LD, 1));
        tbl.push_back(mkv(1, mki(1, 3'b110), LD, 3, 0, 2'b00, 1, 1, 5, LD, 32'h1234_5678, LD, 1));
        tbl.push_back(mkv(1, mki(1, 3'b111), LD, 1, 0, 2'b00, 1, 1, 5, LD, 32'h1234_5678, LD, 1));
        tbl.push_back(mkv(1, NOP, 0, 0, 0, 2'b01, 0, 1, 5, LD, 32'h1234_5678, 0, 0));
        tbl.push_back(mkv(1, mki(1, 3'b000), LD, 32'h0000_FFFF, 32'h0000_0104, 2'b10, 1, 1, 2, 32'h0000_0104, 0, 32'h0000_0104, 1));
        tbl.push_back(mkv(1, NOP, 0, 0, 0, 2'b01, 0, 1, 1, 32'h0000_0104, 32'h0000_0104, 0, 0));
        tbl.push_back(mkv(1, mki(2, 3'b000), LD, 32'hCAFE_F00D, 32'h0000_0200, 2'b11, 1, 2, 1, 32'hCAFE_F00D, 32'h0000_0104, 32'hCAFE_F00D, 1));
        tbl.push_back(mkv(1, NOP, 0, 0, 32'h0000_0055, 2'b10, 0, 2, 5, 32'hCAFE_F00D, 32'h1234_5678, 32'h0000_0055, 0));
        tbl.push_back(mkv(1, mki(3, 3'b000), 0, 32'h0000_1111, 0, 2'b01, 0, 3, 2, 0, 32'hCAFE_F00D, 32'h0000_1111, 0));
        tbl.push_back(mkv(1, 32'h0, 0, 0, 0, 2'b01, 0, 3, 0, 0, 0, 0, 0));
        foreach (tbl[k]) apply(tbl[k]);

        // Ten instructions, three of them bubbles: seven retirements.
        base = exp_instret;
        for (int k = 0; k < 10; k++)
            apply(mkv(1, (k == 2 || k == 5 || k == 8) ? NOP : mki(0, 3'b010),
                      0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        check("instret_stream", instret_o, base + 32'd7);

        // Counter wrap from 2^32-1 to 0.
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFE;
        apply(mkv(1, mki(0, 3'b010), 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        apply(mkv(1, mki(0, 3'b010), 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));
        check("instret_wrap", instret_o, 32'h0);
        apply(mkv(1, NOP, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0));

        // One-cycle reset mid-stream while x7 is being rewritten.
        apply(mkv(1, mki(7, 3'b000), 0, 32'h0000_0055, 0, 2'b01, 1, 7, 5, 32'h0000_0055, 32'h1234_5678, 32'h0000_0055, 1));
        apply(mkv(0, mki(7, 3'b000), 0, 32'h0000_0099, 0, 2'b01, 1, 7, 7, 0, 0, 32'h0000_0099, 0));
        check("instret_after_rst", instret_o, 32'h0);
        apply(mkv(1, NOP, 0, 0, 0, 2'b01, 0, 7, 5, 0, 0, 0, 0));
        apply(mkv(1, NOP, 0, 0, 0, 2'b01, 0, 1, 2, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
